// File: rtl/avalon_wait_mem_pkg.sv
// rtl/avalon_wait_mem_pkg.sv - shared types and constants for avalon_wait_mem
// Purpose: FSM state encoding, out-of-window read data, LFSR constants and step function.
package avalon_wait_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  localparam int LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15],[13],[12],[10].
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avalon_wait_mem_lfsr16.sv
// rtl/avalon_wait_mem_lfsr16.sv - free-running 16-bit Fibonacci LFSR
// Purpose: pseudo-random source for extra stall cycles; advances every clock.
// Ports: clk, reset (async, active-high), lfsr_out (current LFSR state).
module lfsr16
  import avalon_wait_mem_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] lfsr_out
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_out = lfsr_q;

endmodule

// File: rtl/avalon_wait_mem.sv
// rtl/avalon_wait_mem.sv - Avalon-MM responder memory with programmable wait states
// Purpose: DEPTH x 32-bit memory at BASE_ADDR answering single-word reads/writes
//          through waitrequest, with fixed plus optional pseudo-random stalls.
// Ports: clk, reset (async, active-high);
//        avs_read, avs_write, avs_address, avs_writedata (command side);
//        avs_readdata, avs_waitrequest (response side);
//        rd_count, wr_count (wrapping), err_count (saturating).
module avalon_wait_mem
  import avalon_wait_mem_pkg::*;
#(
  parameter logic [31:0]       BASE_ADDR   = 32'h0000_0000,
  parameter int                ADDR_W      = 6,
  parameter int                WAIT_CYCLES = 2,
  parameter bit                RAND_STALL  = 1'b0,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [7:0]  err_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       rd_count_q, rd_count_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [31:0]       mem_q [DEPTH];

  logic [LFSR_W-1:0] lfsr;
  logic              cmd, both, in_win, complete, stall, mem_we;
  logic [ADDR_W-1:0] idx;
  logic [4:0]        stall_t;
  logic              unused_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .lfsr_out (lfsr)
  );

  assign cmd     = avs_read | avs_write;
  assign both    = avs_read & avs_write;
  assign idx     = avs_address[ADDR_W+1:2];
  assign in_win  = (avs_address[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign stall_t = 5'(WAIT_CYCLES) + (RAND_STALL ? {3'b000, lfsr[1:0]} : 5'd0);

  assign unused_bits = ^{lfsr[LFSR_W-1:2], avs_address[1:0]};

  // Stall handshake. An initiator dropping its command mid-stall aborts the
  // transfer without side effects; the next command pays a fresh stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd) begin
          if (stall_t == 5'd0) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = stall_t - 5'd1;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!cmd) begin
          state_d = IDLE;
        end else if (cnt_q != 5'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 5'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // Simultaneous read+write is serviced as a write and also flagged as an error.
  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    mem_we      = 1'b0;
    if (complete) begin
      if (avs_write) begin
        if (in_win) begin
          mem_we     = 1'b1;
          wr_count_d = wr_count_q + 16'd1;
        end
      end else if (in_win) begin
        rd_count_d = rd_count_q + 16'd1;
      end
      if ((both || !in_win) && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_comb begin
    avs_readdata = '0;
    if (!reset && complete && avs_read && !avs_write) begin
      avs_readdata = in_win ? mem_q[idx] : ERR_DATA;
    end
  end

  assign avs_waitrequest = reset | stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
      if (mem_we) begin
        mem_q[idx] <= avs_writedata;
      end
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_avalon_wait_mem.sv
// tb/tb_avalon_wait_mem.sv - scoreboard bench for avalon_wait_mem
// Three instances: 0 = no wait states, 1 = three fixed wait states,
// 2 = two fixed plus 0..3 pseudo-random wait states.
module tb_avalon_wait_mem;

  localparam logic [31:0] BASE = 32'h4000_0100;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        rd, wr, wt;
  logic [2:0][31:0]  addr, wdata, rdata;
  logic [2:0][15:0]  rdc, wrc;
  logic [2:0][7:0]   errc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    int          smin;
    int          smax;
  } exp_t;

  exp_t exp_q [3][$];
  int   sc [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    avalon_wait_mem #(
      .BASE_ADDR   (BASE),
      .ADDR_W      (6),
      .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 2)),
      .RAND_STALL  (g == 2),
      .LFSR_SEED   (16'hACE1)
    ) u_dut (
      .clk             (clk),
      .reset           (rst),
      .avs_read        (rd[g]),
      .avs_write       (wr[g]),
      .avs_address     (addr[g]),
      .avs_writedata   (wdata[g]),
      .avs_readdata    (rdata[g]),
      .avs_waitrequest (wt[g]),
      .rd_count        (rdc[g]),
      .wr_count        (wrc[g]),
      .err_count       (errc[g])
    );
  end

  // Monitor: counts stall cycles and checks every completion against the queue.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst || !(rd[d] | wr[d])) begin
        sc[d] = 0;
      end else if (wt[d]) begin
        sc[d] = sc[d] + 1;
      end else begin
        if (exp_q[d].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion dut=%0d act=completion exp=none", d);
        end else begin
          exp_t e;
          e = exp_q[d].pop_front();
          checks++;
          if (rdata[d] !== e.data) begin
            failures++;
            $display("FAIL readdata dut=%0d act=%h exp=%h", d, rdata[d], e.data);
          end
          checks++;
          if (sc[d] < e.smin || sc[d] > e.smax) begin
            failures++;
            $display("FAIL stall_cycles dut=%0d act=%0d exp=%0d..%0d", d, sc[d], e.smin, e.smax);
          end
        end
        sc[d] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Issue one transfer, hold it until completion (bounded), then drop the command.
  task automatic xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp,
                      input int smin, input int smax);
    exp_t e;
    bit   done;
    int   n;
    e.data = exp;
    e.smin = smin;
    e.smax = smax;
    exp_q[d].push_back(e);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
    done = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      done = !wt[d];
      @(posedge clk);
      #1;
      n++;
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout dut=%0d act=%0d_cycles exp=completion", d, n);
    end
  endtask

  task automatic chk_counts(input string nm, input int d, input int r, input int w, input int e);
    chk({nm, "_rd_count"}, 32'(rdc[d]), r);
    chk({nm, "_wr_count"}, 32'(wrc[d]), w);
    chk({nm, "_err_count"}, 32'(errc[d]), e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] model [64];
    int          nr, nw;

    rst = 1'b1;
    rd = '0; wr = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_waitreq", 32'(wt[d]), 32'd1);
      chk("reset_readdata", rdata[d], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk_counts("post_reset", d, 0, 0, 0);
      chk("idle_waitreq", 32'(wt[d]), 32'd0);
    end

    // Zero wait states: write then read next cycle, window and dual-command cases.
    xfer(0, 0, 1, BASE + 32'h8, 32'h1234_5678, 32'h0, 0, 0);
    xfer(0, 1, 0, BASE + 32'h8, 32'h0, 32'h1234_5678, 0, 0);
    chk_counts("w0_basic", 0, 1, 1, 0);
    xfer(0, 1, 0, BASE + 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    xfer(0, 1, 0, BASE - 32'h4, 32'h0, 32'hDEAD_BEEF, 0, 0);
    chk_counts("w0_oow_read", 0, 1, 1, 2);
    xfer(0, 0, 1, BASE + 32'h108, 32'hCAFE_F00D, 32'h0, 0, 0);
    xfer(0, 1, 0, BASE + 32'h8, 32'h0, 32'h1234_5678, 0, 0);
    chk_counts("w0_oow_write", 0, 2, 1, 3);
    xfer(0, 1, 1, BASE + 32'hC, 32'hA5A5_5A5A, 32'h0, 0, 0);
    xfer(0, 1, 0, BASE + 32'hC, 32'h0, 32'hA5A5_5A5A, 0, 0);
    xfer(0, 1, 0, BASE + 32'hF, 32'h0, 32'hA5A5_5A5A, 0, 0);
    chk_counts("w0_dual", 0, 4, 2, 4);

    // Three fixed wait states: exact stall, abort after one stall cycle, reissue.
    xfer(1, 1, 0, BASE + 32'h4, 32'h0, 32'h0, 3, 3);
    wr[1] = 1'b1; addr[1] = BASE + 32'h10; wdata[1] = 32'h0BAD_F00D;
    @(negedge clk);
    chk("abort_waitreq", 32'(wt[1]), 32'd1);
    @(posedge clk);
    #1;
    wr[1] = 1'b0;
    @(posedge clk);
    #1;
    chk_counts("w3_abort", 1, 1, 0, 0);
    xfer(1, 1, 0, BASE + 32'h10, 32'h0, 32'h0, 3, 3);
    xfer(1, 0, 1, BASE + 32'h10, 32'h0BAD_F00D, 32'h0, 3, 3);
    xfer(1, 1, 0, BASE + 32'h10, 32'h0, 32'h0BAD_F00D, 3, 3);
    chk_counts("w3_reissue", 1, 3, 1, 0);

    // Random stall mode: 100 transfers against a shadow memory.
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    nr = 0;
    nw = 0;
    xfer(2, 1, 0, BASE + 32'h4, 32'h0, 32'h0, 2, 5);
    nr++;
    for (int i = 0; i < 100; i++) begin
      int          ix;
      logic [31:0] dv;
      ix = int'($urandom_range(0, 63));
      dv = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        xfer(2, 0, 1, BASE + 32'(ix * 4), dv, 32'h0, 2, 5);
        model[ix] = dv;
        nw++;
      end else begin
        xfer(2, 1, 0, BASE + 32'(ix * 4), 32'h0, model[ix], 2, 5);
        nr++;
      end
    end
    chk_counts("rand", 2, nr, nw, 0);

    // Reset in the middle of a pending write; a zero-wait read is held across reset.
    wr[1] = 1'b1; addr[1] = BASE + 32'h10; wdata[1] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd[0] = 1'b1; addr[0] = BASE + 32'h8;
    @(negedge clk);
    chk("rst_stall_waitreq", 32'(wt[1]), 32'd1);
    chk("rst_stall_readdata", rdata[1], 32'd0);
    chk("rst_read_waitreq", 32'(wt[0]), 32'd1);
    chk("rst_read_readdata", rdata[0], 32'd0);
    @(posedge clk);
    #1;
    rd[0] = 1'b0;
    wr[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk_counts("after_reset", d, 0, 0, 0);
    xfer(1, 1, 0, BASE + 32'h10, 32'h0, 32'h0, 3, 3);
    xfer(0, 1, 0, BASE + 32'h8, 32'h0, 32'h0, 0, 0);
    xfer(0, 1, 0, BASE + 32'hC, 32'h0, 32'h0, 0, 0);
    xfer(2, 1, 0, BASE + 32'hC, 32'h0, 32'h0, 2, 5);
    chk_counts("after_reset_reads", 1, 1, 0, 0);

    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("queue_drained", 32'(exp_q[d].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
